// File: rtl/free_list_if.sv
// free_list_if
// Purpose: groups the rename-side allocation handshake and the commit-side
// reclaim signals of the physical-register free list into one bundle.
// Ports (signals):
//   alloc_valid_i  rename stage fires this cycle
//   alloc_req_i    per-slot "needs a destination preg"
//   alloc_ready_o  enough free entries for every requesting slot
//   preg_o         allocated preg per decode slot
//   commit_dest_i  per-slot "committing instruction had a destination"
//   free_i         per-slot "release old preg"
//   free_preg_i    old preg to release per commit slot
//   restore_i      pipeline flush, discard speculative allocations
//   free_count_o   number of entries currently free
// Modports: master = rename/commit logic, slave = free list.
interface free_list_if #(
   parameter int PHY_REG_NUM  = 64,
   parameter int DECODE_WIDTH = 2,
   parameter int COMMIT_WIDTH = 2
);
   localparam int PW = $clog2(PHY_REG_NUM);

   logic                                alloc_valid_i;
   logic [DECODE_WIDTH-1:0]             alloc_req_i;
   logic                                alloc_ready_o;
   logic [DECODE_WIDTH-1:0][PW-1:0]     preg_o;
   logic [COMMIT_WIDTH-1:0]             commit_dest_i;
   logic [COMMIT_WIDTH-1:0]             free_i;
   logic [COMMIT_WIDTH-1:0][PW-1:0]     free_preg_i;
   logic                                restore_i;
   logic [PW:0]                         free_count_o;

   modport master (
      output alloc_valid_i, alloc_req_i, commit_dest_i, free_i, free_preg_i, restore_i,
      input  alloc_ready_o, preg_o, free_count_o
   );

   modport slave (
      input  alloc_valid_i, alloc_req_i, commit_dest_i, free_i, free_preg_i, restore_i,
      output alloc_ready_o, preg_o, free_count_o
   );
endinterface

// File: rtl/free_list.sv
// free_list
// Purpose: circular FIFO of free physical-register IDs. Hands compacted free
// pregs to the rename stage, reclaims old pregs at commit, and keeps an
// architectural head so a flush returns every speculative allocation at once.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    free_list_if.slave (allocation, commit/free, restore, count)
module free_list #(
   parameter int PHY_REG_NUM  = 64,
   parameter int DECODE_WIDTH = 2,
   parameter int COMMIT_WIDTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   free_list_if.slave    bus
);
   localparam int PW   = $clog2(PHY_REG_NUM);
   localparam int PTRW = PW + 1;

   typedef logic [PTRW-1:0] ptr_t;

   localparam ptr_t MAX_FREE = ptr_t'(PHY_REG_NUM - 1);

   logic [PW-1:0] r_entry [PHY_REG_NUM];
   ptr_t          r_head;
   ptr_t          r_tail;
   ptr_t          r_archHead;

   ptr_t                    w_count;
   ptr_t                    w_specCount;
   ptr_t                    w_allocN;
   ptr_t                    w_freeN;
   ptr_t                    w_commitN;
   ptr_t                    w_rdPtr [DECODE_WIDTH];
   ptr_t                    w_wrPtr [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] w_freeQual;
   logic                    w_ready;
   logic                    w_fire;

   // Pointers carry one extra wrap bit, so tail - head distinguishes a full
   // list (PHY_REG_NUM) from an empty one (0).
   // Each requesting slot reads the entry at head plus the number of
   // requesting slots below it, which compacts allocations toward the head.
   always_comb begin
      w_count     = r_tail - r_head;
      w_specCount = r_head - r_archHead;
      w_allocN    = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         w_rdPtr[i] = r_head + w_allocN;
         if (bus.alloc_req_i[i]) begin
            w_allocN = w_allocN + ptr_t'(1);
         end
      end
      w_ready = (w_count >= w_allocN);
      w_fire  = bus.alloc_valid_i & w_ready & ~bus.restore_i;
   end

   // Freeing preg 0 is dropped; qualifying frees are packed onto the tail in
   // slot order.
   always_comb begin
      w_freeN   = '0;
      w_commitN = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         w_freeQual[j] = bus.free_i[j] & (bus.free_preg_i[j] != '0);
         w_wrPtr[j]    = r_tail + w_freeN;
         if (w_freeQual[j]) begin
            w_freeN = w_freeN + ptr_t'(1);
         end
         if (bus.commit_dest_i[j]) begin
            w_commitN = w_commitN + ptr_t'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         bus.preg_o[i] = r_entry[w_rdPtr[i][PW-1:0]];
      end
      bus.alloc_ready_o = w_ready;
      bus.free_count_o  = w_count;
   end

   // Reset seeds entry[i] = i+1; the truncating cast makes the last entry 0,
   // and tail stops one short of full so preg 0 is never handed out.
   // Restore takes priority over allocation and lands head on the new
   // architectural head, which already includes this cycle's commits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PHY_REG_NUM; i++) begin
            r_entry[i] <= PW'(i + 1);
         end
         r_head     <= '0;
         r_archHead <= '0;
         r_tail     <= MAX_FREE;
      end else begin
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (w_freeQual[j]) begin
               r_entry[w_wrPtr[j][PW-1:0]] <= bus.free_preg_i[j];
            end
         end
         r_tail     <= r_tail + w_freeN;
         r_archHead <= r_archHead + w_commitN;
         if (bus.restore_i) begin
            r_head <= r_archHead + w_commitN;
         end else if (w_fire) begin
            r_head <= r_head + w_allocN;
         end
      end
   end

   // Freeing into a list that cannot hold the extra entries would overwrite
   // live IDs.
   a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
      (w_count + w_freeN) <= MAX_FREE);

   // Commits can only retire pregs that were already allocated.
   a_archBehindHead: assert property (@(posedge clk) disable iff (!rst_n)
      w_commitN <= w_specCount);
endmodule

// File: tb/tb_free_list.sv
// tb_free_list
// Purpose: self-checking bench for free_list. A queue-based model tracks the
// free IDs in order plus the speculatively allocated IDs. Expected outputs
// are pushed to scoreboard queues as each cycle is driven, then popped and
// compared once the DUT output is valid.
module tb_free_list;
   localparam int PHY_REG_NUM  = 64;
   localparam int DECODE_WIDTH = 2;
   localparam int COMMIT_WIDTH = 2;
   localparam int PW           = $clog2(PHY_REG_NUM);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   int    freeQ[$];
   int    allocHist[$];
   string combTagQ[$];
   int    combExpQ[$];
   string regTagQ[$];
   int    regExpQ[$];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   free_list_if #(
      .PHY_REG_NUM (PHY_REG_NUM),
      .DECODE_WIDTH(DECODE_WIDTH),
      .COMMIT_WIDTH(COMMIT_WIDTH)
   ) bus ();

   free_list #(
      .PHY_REG_NUM (PHY_REG_NUM),
      .DECODE_WIDTH(DECODE_WIDTH),
      .COMMIT_WIDTH(COMMIT_WIDTH)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Maps a scoreboard tag onto the DUT output it describes.
   function automatic int observe(input string tag);
      if (tag == "ready") return int'(bus.alloc_ready_o);
      if (tag == "preg0") return int'(bus.preg_o[0]);
      if (tag == "preg1") return int'(bus.preg_o[1]);
      if (tag == "count") return int'(bus.free_count_o);
      return -1;
   endfunction

   // Reset contents: IDs 1..PHY_REG_NUM-1 free in ascending order.
   task automatic modelReset();
      freeQ.delete();
      allocHist.delete();
      for (int i = 1; i < PHY_REG_NUM; i++) freeQ.push_back(i);
   endtask

   // Drives one cycle, pushes the expected comb outputs and the expected
   // post-edge count, advances the model, then drains both scoreboards.
   task automatic applyStimulus(input bit rstN, input bit valid, input logic [1:0] req,
                                input logic [1:0] cdest, input logic [1:0] fr,
                                input int fp0, input int fp1, input bit rest,
                                input string name);
      int    n;
      int    off;
      int    nCommit;
      bit    ready;
      bit    fire;
      string tag;
      int    exp;
      @(negedge clk);
      rst_n              = rstN;
      bus.alloc_valid_i  = valid;
      bus.alloc_req_i    = req;
      bus.commit_dest_i  = cdest;
      bus.free_i         = fr;
      bus.free_preg_i[0] = PW'(fp0);
      bus.free_preg_i[1] = PW'(fp1);
      bus.restore_i      = rest;

      n     = int'(req[0]) + int'(req[1]);
      ready = (freeQ.size() >= n);
      if (rstN) begin
         combTagQ.push_back("ready");
         combExpQ.push_back(int'(ready));
         if (ready) begin
            off = 0;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
               if (req[i]) begin
                  combTagQ.push_back(i == 0 ? "preg0" : "preg1");
                  combExpQ.push_back(freeQ[off]);
                  off++;
               end
            end
         end
      end
      #1;
      while (combTagQ.size() > 0) begin
         tag = combTagQ.pop_front();
         exp = combExpQ.pop_front();
         checkOutput({name, ".", tag}, observe(tag), exp);
      end

      if (!rstN) begin
         modelReset();
      end else begin
         fire = valid && ready && !rest;
         if (fire) repeat (n) allocHist.push_back(freeQ.pop_front());
         nCommit = int'(cdest[0]) + int'(cdest[1]);
         repeat (nCommit) if (allocHist.size() > 0) void'(allocHist.pop_front());
         if (rest) begin
            for (int i = allocHist.size() - 1; i >= 0; i--) freeQ.push_front(allocHist[i]);
            allocHist.delete();
         end
         if (fr[0] && fp0 != 0) freeQ.push_back(fp0);
         if (fr[1] && fp1 != 0) freeQ.push_back(fp1);
      end
      regTagQ.push_back("count");
      regExpQ.push_back(freeQ.size());

      @(posedge clk);
      #1;
      while (regTagQ.size() > 0) begin
         tag = regTagQ.pop_front();
         exp = regExpQ.pop_front();
         checkOutput({name, ".", tag}, observe(tag), exp);
      end
   endtask

   // Directed sequence: reset, compaction, exhaustion, free/wrap, restore,
   // and reset in the middle of a busy cycle.
   initial begin
      bus.alloc_valid_i = 1'b0;
      bus.alloc_req_i   = '0;
      bus.commit_dest_i = '0;
      bus.free_i        = '0;
      bus.free_preg_i   = '0;
      bus.restore_i     = 1'b0;
      modelReset();

      $display("[TB] reset and first allocation");
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, "rst");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "fire11");
      applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "peek");

      $display("[TB] compaction");
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, "rst2");
      applyStimulus(1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 0, 0, 1'b0, "cmp10");
      applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0, "cmp01");

      $display("[TB] exhaustion");
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, "rst3");
      for (int k = 0; k < 31; k++) begin
         applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "exh");
      end
      applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0, "exhLast");
      applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0, "empty01");
      applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, "empty00");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "empty11");

      $display("[TB] free and wrap");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 5, 9, 1'b0, "freeNoBypass");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "allocFreed");
      applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 0, 7, 1'b0, "freeZeroAnd7");
      applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 0, 0, 1'b0, "freeZero");
      applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 0, 0, 1'b0, "alloc7");

      $display("[TB] restore");
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0, "rst4");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "alloc6");
      end
      applyStimulus(1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 0, 0, 1'b0, "commit2");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b01, 2'b00, 0, 0, 1'b1, "restore");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "afterRestore");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b01, 2'b01, 1, 0, 1'b1, "restoreFree");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "afterRestore2");

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "busy");
      applyStimulus(1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 3, 4, 1'b1, "rstBusy");
      applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0, "postRst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
